// File: rtl/enet_tx_ctrl.sv
// 10BASE-T frame transmit sequencer: preamble, SFD, payload, optional pad, CRC-32 FCS, IFG.
// Define ENET_TX_PAD_EN to zero-pad short frames up to MIN_PAYLOAD bytes before the FCS.
module enet_tx_ctrl #(
    parameter int unsigned IFG_CYCLES  = 192,
    parameter int unsigned MIN_PAYLOAD = 60
) (
    input  logic       clk_20mhz,
    input  logic       rst_ni,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    input  logic       pls_busy,
    output logic       data_enable,
    output logic       txd_out,
    output logic       tx_active,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int unsigned IfgW    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [31:0] CrcPoly = 32'hEDB88320;
    localparam logic [7:0]  SfdByte = 8'hD5;
    localparam logic [10:0] CntMax  = 11'h7FF;
`ifdef ENET_TX_PAD_EN
    localparam bit PadEn = 1'b1;
`else
    localparam bit PadEn = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle, StPre, StSfd, StData, StPad, StFcs, StIfg
    } state_e;

    state_e          r_state, w_state_d;
    logic            r_phase, w_phase_d;
    logic [5:0]      r_bit_cnt, w_bit_cnt_d;
    logic [7:0]      r_shift, w_shift_d;
    logic [31:0]     r_crc, w_crc_d;
    logic [31:0]     r_fcs, w_fcs_d;
    logic [10:0]     r_byte_cnt, w_byte_cnt_d;
    logic [IfgW-1:0] r_ifg_cnt, w_ifg_cnt_d;
    logic            r_last, w_last_d;
    logic            r_underrun, w_underrun_d;
    logic            r_done, w_done_d;
    logic            r_err, w_err_d;

    logic [31:0] w_crc_step;
    logic [10:0] w_cnt_inc;
    logic        w_below_min;
    logic        w_ready;

    // One reflected CRC step over the bit currently on the wire.
    assign w_crc_step  = {1'b0, r_crc[31:1]} ^ ((r_crc[0] ^ r_shift[0]) ? CrcPoly : 32'h0);
    assign w_cnt_inc   = (r_byte_cnt == CntMax) ? r_byte_cnt : r_byte_cnt + 11'd1;
    assign w_below_min = r_byte_cnt < 11'(MIN_PAYLOAD);

    always_ff @(posedge clk_20mhz or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= StIdle;
            r_phase    <= 1'b0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_crc      <= 32'hFFFF_FFFF;
            r_fcs      <= '0;
            r_byte_cnt <= '0;
            r_ifg_cnt  <= '0;
            r_last     <= 1'b0;
            r_underrun <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_phase    <= w_phase_d;
            r_bit_cnt  <= w_bit_cnt_d;
            r_shift    <= w_shift_d;
            r_crc      <= w_crc_d;
            r_fcs      <= w_fcs_d;
            r_byte_cnt <= w_byte_cnt_d;
            r_ifg_cnt  <= w_ifg_cnt_d;
            r_last     <= w_last_d;
            r_underrun <= w_underrun_d;
            r_done     <= w_done_d;
            r_err      <= w_err_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_phase_d    = 1'b0;
        w_bit_cnt_d  = r_bit_cnt;
        w_shift_d    = r_shift;
        w_crc_d      = r_crc;
        w_fcs_d      = r_fcs;
        w_byte_cnt_d = r_byte_cnt;
        w_ifg_cnt_d  = r_ifg_cnt;
        w_last_d     = r_last;
        w_underrun_d = r_underrun;
        w_done_d     = 1'b0;
        w_err_d      = 1'b0;
        w_ready      = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_byte_cnt_d = '0;
                w_crc_d      = 32'hFFFF_FFFF;
                w_bit_cnt_d  = '0;
                w_last_d     = 1'b0;
                w_underrun_d = 1'b0;
                if (tx_valid && !pls_busy && (r_ifg_cnt == '0)) begin
                    w_state_d = StPre;
                end
            end
            StPre: begin
                w_phase_d = ~r_phase;
                if (r_phase) begin
                    w_bit_cnt_d = r_bit_cnt + 6'd1;
                    if (r_bit_cnt == 6'd55) begin
                        w_bit_cnt_d = '0;
                        w_shift_d   = SfdByte;
                        w_state_d   = StSfd;
                    end
                end
            end
            StSfd, StData: begin
                w_phase_d = ~r_phase;
                if (r_phase) begin
                    w_shift_d   = {1'b0, r_shift[7:1]};
                    w_bit_cnt_d = r_bit_cnt + 6'd1;
                    if (r_state == StData) begin
                        w_crc_d = w_crc_step;
                    end
                    if (r_bit_cnt == 6'd7) begin
                        w_bit_cnt_d = '0;
                        if (r_state == StData && r_last) begin
                            if (PadEn && w_below_min) begin
                                w_shift_d    = '0;
                                w_byte_cnt_d = w_cnt_inc;
                                w_state_d    = StPad;
                            end else begin
                                w_fcs_d   = ~w_crc_step;
                                w_state_d = StFcs;
                            end
                        end else begin
                            w_ready = 1'b1;
                            if (tx_valid) begin
                                w_shift_d    = tx_data;
                                w_last_d     = tx_last;
                                w_byte_cnt_d = w_cnt_inc;
                                w_state_d    = StData;
                            end else begin
                                // Underrun: send the raw register so the receiver sees a bad FCS.
                                w_fcs_d      = (r_state == StData) ? w_crc_step : r_crc;
                                w_underrun_d = 1'b1;
                                w_state_d    = StFcs;
                            end
                        end
                    end
                end
            end
`ifdef ENET_TX_PAD_EN
            StPad: begin
                w_phase_d = ~r_phase;
                if (r_phase) begin
                    w_shift_d   = {1'b0, r_shift[7:1]};
                    w_bit_cnt_d = r_bit_cnt + 6'd1;
                    w_crc_d     = w_crc_step;
                    if (r_bit_cnt == 6'd7) begin
                        w_bit_cnt_d = '0;
                        if (w_below_min) begin
                            w_shift_d    = '0;
                            w_byte_cnt_d = w_cnt_inc;
                        end else begin
                            w_fcs_d   = ~w_crc_step;
                            w_state_d = StFcs;
                        end
                    end
                end
            end
`endif
            StFcs: begin
                w_phase_d = ~r_phase;
                if (r_phase) begin
                    w_fcs_d     = {1'b0, r_fcs[31:1]};
                    w_bit_cnt_d = r_bit_cnt + 6'd1;
                    if (r_bit_cnt == 6'd31) begin
                        w_bit_cnt_d = '0;
                        w_phase_d   = 1'b0;
                        w_ifg_cnt_d = IfgW'(IFG_CYCLES - 1);
                        w_done_d    = ~r_underrun;
                        w_err_d     = r_underrun;
                        w_state_d   = StIfg;
                    end
                end
            end
            StIfg: begin
                if (r_ifg_cnt == '0) begin
                    w_state_d = StIdle;
                end else begin
                    w_ifg_cnt_d = r_ifg_cnt - IfgW'(1);
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        txd_out = 1'b0;
        unique case (r_state)
            StPre:                txd_out = ~r_bit_cnt[0];
            StSfd, StData, StPad: txd_out = r_shift[0];
            StFcs:                txd_out = r_fcs[0];
            default:              txd_out = 1'b0;
        endcase
    end

    assign data_enable = (r_state == StPre) || (r_state == StSfd) || (r_state == StData) ||
                         (r_state == StPad) || (r_state == StFcs);
    assign tx_ready    = w_ready;
    assign tx_active   = (r_state != StIdle);
    assign tx_done     = r_done;
    assign tx_err      = r_err;

endmodule

// File: tb/tb_enet_tx_ctrl.sv
// Directed bench for enet_tx_ctrl: decodes the serial stream and checks framing, CRC and timing.
// Follows ENET_TX_PAD_EN the same way as the design.
module tb_enet_tx_ctrl;

    localparam int IfgCycles  = 192;
    localparam int MinPayload = 60;
`ifdef ENET_TX_PAD_EN
    localparam bit PadEn = 1'b1;
`else
    localparam bit PadEn = 1'b0;
`endif

    logic       clk_20mhz = 1'b0;
    logic       rst_ni    = 1'b0;
    logic [7:0] tx_data   = 8'h00;
    logic       tx_valid  = 1'b0;
    logic       tx_last   = 1'b0;
    logic       pls_busy  = 1'b0;
    logic       tx_ready, data_enable, txd_out, tx_active, tx_done, tx_err;

    enet_tx_ctrl #(
        .IFG_CYCLES (IfgCycles),
        .MIN_PAYLOAD(MinPayload)
    ) dut (
        .clk_20mhz  (clk_20mhz),
        .rst_ni     (rst_ni),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_last    (tx_last),
        .tx_ready   (tx_ready),
        .pls_busy   (pls_busy),
        .data_enable(data_enable),
        .txd_out    (txd_out),
        .tx_active  (tx_active),
        .tx_done    (tx_done),
        .tx_err     (tx_err)
    );

    always #25 clk_20mhz = ~clk_20mhz;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] pl    [64];
    logic [7:0] exp_b [128];
    int         n_pl;
    bit         rx_bits[$];
    int         de_cycles, ready_first, n_ready, n_done, n_err, pre_wait;
    bit         fall_seen;

    function automatic logic [7:0] rx_byte(input int k);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = (8 * k + i < rx_bits.size()) ? rx_bits[8 * k + i] : 1'b0;
        return b;
    endfunction

    function automatic logic [31:0] rx_word(input int k);
        return {rx_byte(k + 3), rx_byte(k + 2), rx_byte(k + 1), rx_byte(k)};
    endfunction

    // Reference CRC register after n bytes of exp_b (reflected 0xEDB88320, init all ones).
    function automatic logic [31:0] crc_reg(input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 8; j++) begin
                if (c[0] ^ exp_b[i][j]) c = (c >> 1) ^ 32'hEDB8_8320;
                else c = c >> 1;
            end
        end
        return c;
    endfunction

    // Drives one frame and records txd_out at every phase 0 until data_enable falls.
    // drop_at: deassert tx_valid for that tx_ready; abort_at: pull reset at that de cycle.
    task automatic send_frame(input int drop_at, input bit keep_valid, input int abort_at);
        int idx, cyc;
        bit consume, started;
        rx_bits.delete();
        de_cycles = 0; ready_first = -1; n_ready = 0; n_done = 0; n_err = 0; pre_wait = 0;
        idx = 0; cyc = 0; started = 1'b0; fall_seen = 1'b0;
        tx_data = pl[0]; tx_last = (n_pl == 1); tx_valid = 1'b1;
        for (int t = 0; t < 6000; t++) begin
            @(negedge clk_20mhz);
            consume = 1'b0;
            if (tx_done) n_done++;
            if (tx_err) n_err++;
            if (data_enable) begin
                started = 1'b1;
                if (cyc % 2 == 0) rx_bits.push_back(txd_out);
                if (tx_ready) begin
                    n_ready++;
                    if (ready_first < 0) ready_first = cyc;
                    consume = tx_valid;
                end
                if (abort_at > 0 && cyc == abort_at) begin
                    #5 rst_ni = 1'b0;
                    #1;
                    check_eq("async_reset_outputs",
                             32'({data_enable, txd_out, tx_ready, tx_active, tx_done, tx_err}), 0);
                    tx_valid = 1'b0; tx_last = 1'b0;
                    return;
                end
                cyc++;
                de_cycles++;
            end else if (started) begin
                fall_seen = 1'b1;
                break;
            end else begin
                pre_wait++;
            end
            @(posedge clk_20mhz);
            #1;
            if (consume) begin
                idx++;
                if (idx < n_pl) begin
                    tx_data = pl[idx];
                    tx_last = (idx == n_pl - 1);
                    if (drop_at > 0 && idx == drop_at - 1) tx_valid = 1'b0;
                end else if (keep_valid) begin
                    tx_data = pl[0];
                    tx_last = (n_pl == 1);
                end else begin
                    tx_valid = 1'b0;
                    tx_last  = 1'b0;
                end
            end
        end
        check_eq("frame_completed", 32'(fall_seen), 1);
    endtask

    task automatic check_frame(input string tag, input bit bad_fcs, input int n_sent);
        int n_tot, nbad_pre, nbad_pl;
        logic [31:0] c;
        n_tot = (PadEn && !bad_fcs && n_sent < MinPayload) ? MinPayload : n_sent;
        for (int i = 0; i < n_tot; i++) exp_b[i] = (i < n_sent) ? pl[i] : 8'h00;
        c = crc_reg(n_tot);
        nbad_pre = 0;
        nbad_pl  = 0;
        for (int i = 0; i < 7; i++) if (rx_byte(i) != 8'h55) nbad_pre++;
        for (int i = 0; i < n_tot; i++) if (rx_byte(8 + i) != exp_b[i]) nbad_pl++;
        check_eq({tag, "_de_cycles"}, de_cycles, (8 + n_tot + 4) * 16);
        check_eq({tag, "_preamble_bad_bytes"}, nbad_pre, 0);
        check_eq({tag, "_sfd"}, 32'(rx_byte(7)), 32'hD5);
        check_eq({tag, "_payload_bad_bytes"}, nbad_pl, 0);
        check_eq({tag, "_fcs"}, rx_word(8 + n_tot), bad_fcs ? c : ~c);
    endtask

    initial begin
        repeat (3) @(posedge clk_20mhz);
        @(negedge clk_20mhz);
        check_eq("reset_outputs",
                 32'({data_enable, txd_out, tx_ready, tx_active, tx_done, tx_err}), 0);
        rst_ni = 1'b1;
        repeat (2) @(posedge clk_20mhz);
        #1;

        // "123456789": CRC check value.
        n_pl = 9;
        for (int i = 0; i < 9; i++) pl[i] = 8'h31 + 8'(i);
        send_frame(0, 1'b0, 0);
        check_frame("ascii9", 1'b0, 9);
        check_eq("ascii9_ready_first", ready_first, 127);
        check_eq("ascii9_ready_count", n_ready, 9);
        check_eq("ascii9_done", n_done, 1);
        check_eq("ascii9_err", n_err, 0);
        check_eq("ascii9_active_in_ifg", 32'(tx_active), 1);
`ifndef ENET_TX_PAD_EN
        check_eq("ascii9_fcs_ref", rx_word(17), 32'hCBF4_3926);
`endif
        repeat (200) @(posedge clk_20mhz);
        #1;
        check_eq("ifg_over_idle", 32'(tx_active), 0);

        // Underrun at the 5th tx_ready.
        n_pl = 8;
        for (int i = 0; i < 8; i++) pl[i] = 8'hA0 + 8'(i * 7);
        send_frame(5, 1'b0, 0);
        check_frame("underrun", 1'b1, 4);
        check_eq("underrun_ready_count", n_ready, 5);
        check_eq("underrun_err", n_err, 1);
        check_eq("underrun_done", n_done, 0);
        repeat (200) @(posedge clk_20mhz);
        #1;

`ifdef ENET_TX_PAD_EN
        n_pl = 14;
        for (int i = 0; i < 14; i++) pl[i] = 8'h10 + 8'(i * 13);
        send_frame(0, 1'b0, 0);
        check_frame("pad14", 1'b0, 14);
        check_eq("pad14_de_1152", de_cycles, 1152);
        check_eq("pad14_done", n_done, 1);
        repeat (200) @(posedge clk_20mhz);
        #1;
`endif

        // Back-to-back with tx_valid held, then a held pls_busy.
        n_pl = 1;
        pl[0] = 8'h3C;
        send_frame(0, 1'b1, 0);
        check_frame("b2b_a", 1'b0, 1);
        send_frame(0, 1'b1, 0);
        check_eq("b2b_gap_ge_193", 32'(pre_wait + 1 >= 193), 1);
        check_frame("b2b_b", 1'b0, 1);
        pls_busy = 1'b1;
        fork
            begin
                repeat (400) @(posedge clk_20mhz);
                #1 pls_busy = 1'b0;
            end
        join_none
        send_frame(0, 1'b1, 0);
        tx_valid = 1'b0;
        check_eq("busy_gap", pre_wait + 1, 401);
        check_frame("busy_c", 1'b0, 1);
        repeat (200) @(posedge clk_20mhz);
        #1;

        // Async reset mid-DATA, then a clean frame.
        n_pl = 10;
        for (int i = 0; i < 10; i++) pl[i] = 8'hF0 - 8'(i * 3);
        send_frame(0, 1'b0, 200);
        #10 rst_ni = 1'b1;
        repeat (5) @(posedge clk_20mhz);
        #1;
        n_pl = 9;
        for (int i = 0; i < 9; i++) pl[i] = 8'h31 + 8'(i);
        send_frame(0, 1'b0, 0);
        check_frame("post_reset", 1'b0, 9);
        check_eq("post_reset_done", n_done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
